// File: rtl/gpio_wbarb_pkg.sv
// Shared types and defaults for the GPIO Wishbone arbiter.
package gpio_wbarb_pkg;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/gpio_wbarb_rr_pick.sv
// Round-robin picker: first asserted request searching upward from last+1, wrapping at NM.
module rr_pick #(
    parameter int unsigned NM = 2,
    parameter int unsigned IW = 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] onehot,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= NM; i++) begin
            cand = IW'((32'(last) + i) % NM);
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/gpio_wbarb.sv
// NM-master Wishbone arbiter in front of a single GPIO slave.
// Optional idle-owner timeout with lockout enabled by defining GPIOARB_TIMEOUT_EN.
module gpio_wbarb
    import gpio_wbarb_pkg::*;
#(
    parameter int unsigned NM      = 2,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_areset_n,
    input  logic [NM-1:0]    i_cyc,
    input  logic [NM-1:0]    i_stb,
    input  logic [NM-1:0]    i_we,
    input  logic [NM*32-1:0] i_data,
    output logic [NM-1:0]    o_ack,
    output logic [NM-1:0]    o_stall,
    output logic [31:0]      o_data,
    output logic             o_cyc,
    output logic             o_stb,
    output logic             o_we,
    output logic [31:0]      o_sdata,
    input  logic [31:0]      i_sdata,
    output logic [NM-1:0]    o_grant
);

    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

    arb_state_e    state_q, state_d;
    logic [NM-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [NM-1:0] ack_q, ack_d;
    logic [31:0]   data_q;

    logic [NM-1:0] eligible;
    logic [NM-1:0] pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          own_cyc, own_stb, own_we;
    logic          accept;
    logic          timeout_hit;

    rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_rr_pick (
        .req    (eligible),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Grant is one-hot (or zero), so an OR-reduction acts as the owner mux.
    always_comb begin
        own_cyc = |(i_cyc & grant_q);
        own_stb = |(i_stb & grant_q);
        own_we  = |(i_we & grant_q);
        o_sdata = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant_q[k]) begin
                o_sdata = o_sdata | i_data[32*k +: 32];
            end
        end
    end

    assign accept = (state_q == OWNED) && own_cyc && own_stb;
    assign ack_d  = grant_q & {NM{accept}};

`ifdef GPIOARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [NM-1:0] lockout_q, lockout_d;

    always_comb begin
        cnt_d       = '0;
        timeout_hit = 1'b0;
        lockout_d   = lockout_q & i_cyc;
        if (state_q == OWNED && own_cyc && !own_stb) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
                lockout_d   = lockout_d | grant_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cnt_q     <= '0;
            lockout_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            lockout_q <= lockout_d;
        end
    end

    assign eligible = i_cyc & ~lockout_q;
`else
    // TIMEOUT only matters when the timeout feature is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign eligible       = i_cyc;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = OWNED;
                    grant_d = pick_onehot;
                    last_d  = pick_idx;
                end
            end
            OWNED: begin
                if (!own_cyc || timeout_hit) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
            ack_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ack_q   <= ack_d;
            if (accept) begin
                data_q <= i_sdata;
            end
        end
    end

    // Masking by i_cyc drops an ack whose master has already abandoned the cycle.
    assign o_ack   = ack_q & i_cyc;
    assign o_stall = ~grant_q;
    assign o_data  = data_q;
    assign o_grant = grant_q;
    assign o_cyc   = own_cyc;
    assign o_stb   = own_stb;
    assign o_we    = own_we;

endmodule

// File: tb/tb_gpio_wbarb.sv
// Directed self-checking bench for gpio_wbarb with two masters.
module tb_gpio_wbarb;

    logic        clk = 1'b0;
    logic        areset_n = 1'b1;
    logic [1:0]  cyc = '0, stb = '0, we = '0;
    logic [63:0] data = '0;
    logic [1:0]  ack, stall, grant;
    logic [31:0] odata, osdata;
    logic [31:0] isdata = '0;
    logic        ocyc, ostb, owe;

    int passed = 0;
    int total  = 0;

    gpio_wbarb #(
        .NM      (2),
        .TIMEOUT (4)
    ) dut (
        .i_clk      (clk),
        .i_areset_n (areset_n),
        .i_cyc      (cyc),
        .i_stb      (stb),
        .i_we       (we),
        .i_data     (data),
        .o_ack      (ack),
        .o_stall    (stall),
        .o_data     (odata),
        .o_cyc      (ocyc),
        .o_stb      (ostb),
        .o_we       (owe),
        .o_sdata    (osdata),
        .i_sdata    (isdata),
        .o_grant    (grant)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc = 2'b11; stb = 2'b11; we = 2'b11;
        #2 areset_n = 1'b0;
        #2;
        total++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else passed++;
        total++; if (ack !== 2'b00) $display("FAIL rst_ack: got %b want 00", ack); else passed++;
        total++; if (stall !== 2'b11) $display("FAIL rst_stall: got %b want 11", stall); else passed++;
        total++; if (odata !== 32'h0) $display("FAIL rst_odata: got %h want 0", odata); else passed++;
        total++; if ({ocyc, ostb, owe} !== 3'b000) $display("FAIL rst_obus: got %b want 000", {ocyc, ostb, owe}); else passed++;
        tick;
        tick;
        cyc = '0; stb = '0; we = '0;
        areset_n = 1'b1;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL rst_idle: got %b want 00", grant); else passed++;
    endtask

    task automatic test_single;
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; data[31:0] = 32'h0001_0001;
        isdata = 32'hABCD_1234;
        #1;
        total++; if (stall[0] !== 1'b1) $display("FAIL single_stall0: got %b want 1", stall[0]); else passed++;
        total++; if (ocyc !== 1'b0) $display("FAIL single_ocyc0: got %b want 0", ocyc); else passed++;
        tick;
        total++; if (grant !== 2'b01) $display("FAIL single_grant: got %b want 01", grant); else passed++;
        total++; if (stall[0] !== 1'b0) $display("FAIL single_stall1: got %b want 0", stall[0]); else passed++;
        total++; if (osdata !== 32'h0001_0001) $display("FAIL single_osdata: got %h want 00010001", osdata); else passed++;
        total++; if ({ocyc, ostb, owe} !== 3'b111) $display("FAIL single_obus: got %b want 111", {ocyc, ostb, owe}); else passed++;
        total++; if (ack[0] !== 1'b0) $display("FAIL single_ack_early: got %b want 0", ack[0]); else passed++;
        tick;
        stb[0] = 1'b0;
        #1;
        total++; if (ack !== 2'b01) $display("FAIL single_ack: got %b want 01", ack); else passed++;
        total++; if (odata !== 32'hABCD_1234) $display("FAIL single_odata: got %h want abcd1234", odata); else passed++;
        tick;
        total++; if (ack !== 2'b00) $display("FAIL single_ack_once: got %b want 00", ack); else passed++;
        cyc[0] = 1'b0; we[0] = 1'b0;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL single_release: got %b want 00", grant); else passed++;
    endtask

    task automatic test_priority;
        cyc = '0; stb = '0; we = '0;
        areset_n = 1'b0;
        #1 areset_n = 1'b1;
        cyc = 2'b11;
        #1;
        total++; if (stall !== 2'b11) $display("FAIL prio_stall_idle: got %b want 11", stall); else passed++;
        tick;
        total++; if (grant !== 2'b01) $display("FAIL prio_first: got %b want 01", grant); else passed++;
        total++; if (stall !== 2'b10) $display("FAIL prio_stall_own: got %b want 10", stall); else passed++;
        cyc[0] = 1'b0;
        #1;
        total++; if (ocyc !== 1'b0) $display("FAIL prio_ocyc_drop: got %b want 0", ocyc); else passed++;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL prio_idle: got %b want 00", grant); else passed++;
        tick;
        total++; if (grant !== 2'b10) $display("FAIL prio_second: got %b want 10", grant); else passed++;
        total++; if (stall !== 2'b01) $display("FAIL prio_stall_m1: got %b want 01", stall); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] v [4];
        int acks;
        v[0] = 32'h1234_0001; v[1] = 32'h00FF_FF00; v[2] = 32'hDEAD_BEEF; v[3] = 32'h8001_7FFE;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            stb[1] = 1'b1; we[1] = 1'b1;
            data[63:32] = 32'h0003_0000 | 32'(i);
            isdata = v[i];
            #1;
            total++; if (stall[1] !== 1'b0) $display("FAIL b2b_stall[%0d]: got %b want 0", i, stall[1]); else passed++;
            total++; if (osdata !== (32'h0003_0000 | 32'(i))) $display("FAIL b2b_osdata[%0d]: got %h want %h", i, osdata, 32'h0003_0000 | 32'(i)); else passed++;
            total++; if (ack[1] !== (i != 0)) $display("FAIL b2b_ack[%0d]: got %b want %b", i, ack[1], i != 0); else passed++;
            if (i != 0) begin
                total++; if (odata !== v[i-1]) $display("FAIL b2b_odata[%0d]: got %h want %h", i, odata, v[i-1]); else passed++;
            end
            if (ack[1] === 1'b1) acks++;
            tick;
        end
        stb[1] = 1'b0; we[1] = 1'b0;
        #1;
        total++; if (ack !== 2'b10) $display("FAIL b2b_last_ack: got %b want 10", ack); else passed++;
        total++; if (odata !== v[3]) $display("FAIL b2b_last_odata: got %h want %h", odata, v[3]); else passed++;
        if (ack[1] === 1'b1) acks++;
        total++; if (acks !== 4) $display("FAIL b2b_ack_count: got %0d want 4", acks); else passed++;
        tick;
        total++; if (ack !== 2'b00) $display("FAIL b2b_ack_end: got %b want 00", ack); else passed++;
        cyc[1] = 1'b0;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL b2b_release: got %b want 00", grant); else passed++;
    endtask

    task automatic test_drop;
        cyc[0] = 1'b1;
        tick;
        total++; if (grant !== 2'b01) $display("FAIL drop_grant_wrap: got %b want 01", grant); else passed++;
        stb[0] = 1'b1; isdata = 32'h5555_AAAA;
        tick;
        cyc[0] = 1'b0; stb[0] = 1'b0;
        #1;
        total++; if (ack !== 2'b00) $display("FAIL drop_no_ack: got %b want 00", ack); else passed++;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL drop_idle: got %b want 00", grant); else passed++;
        total++; if (ack !== 2'b00) $display("FAIL drop_no_ack_late: got %b want 00", ack); else passed++;
    endtask

    task automatic test_reset_mid;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; data[63:32] = 32'hFFFF_0F0F;
        tick;
        total++; if (grant !== 2'b10) $display("FAIL midrst_grant: got %b want 10", grant); else passed++;
        tick;
        total++; if (ack !== 2'b10) $display("FAIL midrst_ack: got %b want 10", ack); else passed++;
        areset_n = 1'b0;
        #1;
        total++; if (grant !== 2'b00) $display("FAIL midrst_grant_async: got %b want 00", grant); else passed++;
        total++; if (ack !== 2'b00) $display("FAIL midrst_ack_async: got %b want 00", ack); else passed++;
        total++; if (stall !== 2'b11) $display("FAIL midrst_stall: got %b want 11", stall); else passed++;
        total++; if (ocyc !== 1'b0) $display("FAIL midrst_ocyc: got %b want 0", ocyc); else passed++;
        tick;
        areset_n = 1'b1;
        #1;
        total++; if (grant !== 2'b00) $display("FAIL midrst_still_idle: got %b want 00", grant); else passed++;
        tick;
        total++; if (grant !== 2'b10) $display("FAIL midrst_regrant: got %b want 10", grant); else passed++;
        total++; if (ack !== 2'b00) $display("FAIL midrst_ack_regrant: got %b want 00", ack); else passed++;
        tick;
        total++; if (ack !== 2'b10) $display("FAIL midrst_resume_ack: got %b want 10", ack); else passed++;
        cyc = '0; stb = '0; we = '0;
        tick;
    endtask

`ifdef GPIOARB_TIMEOUT_EN
    task automatic test_timeout;
        areset_n = 1'b0;
        #1 areset_n = 1'b1;
        cyc = 2'b11; stb = '0;
        tick;
        total++; if (grant !== 2'b01) $display("FAIL to_grant_m0: got %b want 01", grant); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (grant !== 2'b01) $display("FAIL to_hold[%0d]: got %b want 01", i, grant); else passed++;
        end
        tick;
        total++; if (grant !== 2'b00) $display("FAIL to_expire: got %b want 00", grant); else passed++;
        tick;
        total++; if (grant !== 2'b10) $display("FAIL to_grant_m1: got %b want 10", grant); else passed++;
        cyc[1] = 1'b0;
        tick;
        tick;
        total++; if (grant !== 2'b00) $display("FAIL to_lockout: got %b want 00", grant); else passed++;
        cyc[0] = 1'b0;
        tick;
        cyc[0] = 1'b1;
        #1;
        total++; if (grant !== 2'b00) $display("FAIL to_rereq_idle: got %b want 00", grant); else passed++;
        tick;
        total++; if (grant !== 2'b01) $display("FAIL to_regrant_m0: got %b want 01", grant); else passed++;
        cyc = '0;
        tick;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_priority;
        test_back_to_back;
        test_drop;
        test_reset_mid;
`ifdef GPIOARB_TIMEOUT_EN
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gpio_wbarb.md
GPIO_WBARB -- requirements
Module: gpio_wbarb

Interface
REQ-001 SHALL have parameter NM, default 2, number of requesting bus masters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, idle-grant cycle limit (used only with GPIOARB_TIMEOUT_EN).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_areset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_cyc, i_stb, i_we  input  NM each  per-master bus cycle, strobe and write-enable.
REQ-006 SHALL have port i_data  input  NM*32  per-master write word; master k occupies bits [32k+31:32k].
REQ-007 SHALL have ports o_ack, o_stall  output  NM each  per-master acknowledge and stall.
REQ-008 SHALL have port o_data  output  32  registered read word, broadcast to all masters.
REQ-009 SHALL have ports o_cyc, o_stb, o_we  output  1 each  to the single GPIO slave.
REQ-010 SHALL have port o_sdata  output  32  write word to the slave (set-mask in [31:16], value in [15:0]).
REQ-011 SHALL have port i_sdata  input  32  slave read word (inputs in [31:16], outputs in [15:0]).
REQ-012 SHALL have port o_grant  output  NM  one-hot current owner, all-zero when idle.

Function
REQ-013 SHALL implement two states: IDLE (no owner) and OWNED (exactly one o_grant bit set).
REQ-014 In IDLE, when any eligible i_cyc is high, SHALL select the owner round-robin, starting the search at last owner +1 modulo NM, and enter OWNED on the next edge.
REQ-015 Arbitration latency SHALL be one cycle: a master raising i_cyc into an idle arbiter sees o_stall high for exactly one cycle.
REQ-016 In OWNED, o_cyc, o_stb, o_we and o_sdata SHALL be a combinational mux of the owner's inputs; non-owners SHALL see o_stall=1 and o_ack=0.
REQ-017 The owner's o_stall SHALL be 0; each owner strobe SHALL be accepted in one cycle, giving one transfer per clock.
REQ-018 o_ack[owner] SHALL pulse exactly one cycle after each accepted strobe; o_data SHALL latch i_sdata on that same edge.
REQ-019 If the owner drops i_cyc, the arbiter SHALL return to IDLE on that edge, and any pending ack SHALL be suppressed.
REQ-020 If the owner drops i_cyc while other requests are pending, SHALL re-arbitrate next cycle; the former owner SHALL have lowest priority.
REQ-021 The owner pointer SHALL wrap from NM-1 to 0.

Reset
REQ-022 SHALL reset asynchronously on i_areset_n low: state IDLE, o_grant=0, o_ack=0, o_data=0, last-owner pointer=NM-1, timeout counter=0, lockout=0.
REQ-023 During reset, o_cyc, o_stb and o_we SHALL be 0, and o_stall SHALL be all-ones.
REQ-024 Reset asserted mid-transfer SHALL drop the grant with no ack issued; release SHALL be synchronous to i_clk.

Configuration
REQ-025 With GPIOARB_TIMEOUT_EN defined, SHALL count consecutive OWNED cycles with the owner's i_stb low.
REQ-026 The counter SHALL reset on any accepted strobe.
REQ-027 On reaching TIMEOUT, SHALL force IDLE, set that master's lockout bit, and treat it as ineligible until it drops i_cyc, which clears the bit.
REQ-028 Without GPIOARB_TIMEOUT_EN, SHALL have no counter and no lockout; ownership SHALL be held indefinitely.

Structure
REQ-029 A shared package gpio_wbarb_pkg SHALL hold the state enum (IDLE, OWNED) and the localparam for the default TIMEOUT.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (request vector plus last index in; one-hot and index out), purely combinational.

Verification
REQ-031 Reset, then m0 cyc+stb+we with data 0x0001_0001 -> o_stall[0]=1 for 1 cycle, o_sdata=0x00010001 next cycle, o_ack[0] one cycle after that.
REQ-032 m0 and m1 raise cyc in the same cycle from reset -> m0 granted first (pointer=NM-1); after m0 drops cyc, m1 granted on the following cycle.
REQ-033 Owner issues 4 back-to-back strobes -> 4 consecutive acks, one per clock; o_data tracks i_sdata delayed by one cycle.
REQ-034 Owner drops cyc in the cycle after a strobe -> no ack pulse; arbiter returns to IDLE.
REQ-035 With GPIOARB_TIMEOUT_EN and TIMEOUT=4, m0 holds cyc with no stb while m1 requests -> m0 loses grant after 4 idle cycles and m1 is granted; m0 is not re-granted until it cycles i_cyc low then high.
REQ-036 Assert i_areset_n low mid-burst -> o_grant=0 and o_ack=0 immediately (asynchronously); burst resumes only after re-arbitration.
